execute_stage: RTL and testbench



---
 rtl/multicore_pkg.sv | 65 ++++++
 rtl/execute_stage_if.sv | 53 +++++
 rtl/execute_stage_muldiv.sv | 153 +++++++++++++++
 rtl/execute_stage.sv | 110 +++++++++++
 tb/tb_execute_stage.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicore_pkg.sv
// Shared types and constants for the multicore pipeline.
// Provides the data/instruction widths, the register-file size, the
// load/store control encodings, the execute-stage operation encoding
// and the multiply/divide iteration count.
package multicore_pkg;

  localparam int DATA_SIZE    = 32;
  localparam int INST_SIZE    = 32;
  localparam int NUM_REGS     = 32;
  localparam int REG_ADDR_W   = $clog2(NUM_REGS);
  localparam int MULDIV_ITERS = 32;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4
  } t_ldop;

  typedef enum logic [1:0] {
    ST_B = 2'd0,
    ST_H = 2'd1,
    ST_W = 2'd2
  } t_sop;

  // 11 single-cycle ALU ops followed by the 8 RV32M ops.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } t_aluop;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } t_md_state;

  function automatic logic is_muldiv(input t_aluop op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_div(input t_aluop op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle of the execute stage.
// i_* signals come from decode/register-read and the hazard unit
// (i_en), o_* signals are the registered EX/MEM values plus the
// combinational stall request o_busy.
//   master : upstream/downstream environment (drives i_*, reads o_*)
//   slave  : execute_stage (reads i_*, drives o_*)
interface execute_stage_if;
  import multicore_pkg::*;

  logic                  i_en;
  logic                  i_valid;
  logic [DATA_SIZE-1:0]  i_opa;
  logic [DATA_SIZE-1:0]  i_opb;
  t_aluop                i_aluop;
  logic [DATA_SIZE-1:0]  i_rs2_data;
  logic [INST_SIZE-1:0]  i_pcplus4;
  logic [REG_ADDR_W-1:0] i_rdest;
  logic                  i_cu_regwrite;
  logic                  i_cu_memaccess;
  logic                  i_mem_we;
  logic [1:0]            i_cu_memtoreg;
  t_ldop                 i_ldop;
  t_sop                  i_sop;

  logic [DATA_SIZE-1:0]  o_exe_out;
  logic [DATA_SIZE-1:0]  o_mem_wdata;
  logic [INST_SIZE-1:0]  o_pcplus4;
  logic [REG_ADDR_W-1:0] o_rdest;
  logic                  o_cu_regwrite;
  logic                  o_cu_memaccess;
  logic                  o_mem_we;
  logic [1:0]            o_cu_memtoreg;
  t_ldop                 o_ldop;
  t_sop                  o_sop;
  logic                  o_busy;

  modport master (
    output i_en, i_valid, i_opa, i_opb, i_aluop, i_rs2_data, i_pcplus4,
           i_rdest, i_cu_regwrite, i_cu_memaccess, i_mem_we,
           i_cu_memtoreg, i_ldop, i_sop,
    input  o_exe_out, o_mem_wdata, o_pcplus4, o_rdest, o_cu_regwrite,
           o_cu_memaccess, o_mem_we, o_cu_memtoreg, o_ldop, o_sop, o_busy
  );

  modport slave (
    input  i_en, i_valid, i_opa, i_opb, i_aluop, i_rs2_data, i_pcplus4,
           i_rdest, i_cu_regwrite, i_cu_memaccess, i_mem_we,
           i_cu_memtoreg, i_ldop, i_sop,
    output o_exe_out, o_mem_wdata, o_pcplus4, o_rdest, o_cu_regwrite,
           o_cu_memaccess, o_mem_we, o_cu_memtoreg, o_ldop, o_sop, o_busy
  );

endinterface

// File: rtl/execute_stage_muldiv.sv
// muldiv_unit: iterative RV32M multiply/divide.
// Ports:
//   i_aclk, i_areset_n : clock, async active-low reset
//   i_start            : valid M op presented (sampled in IDLE only)
//   i_op, i_a, i_b     : operation and operands, held stable while busy
//   i_ack              : EX/MEM advance; releases DONE back to IDLE
//   o_done             : result valid on o_result
//   o_result           : selected word of the final product/quotient/rem
// Operands are reduced to magnitudes up front, a 32-step unsigned
// shift-add multiply or restoring divide runs in a 64-bit accumulator,
// and the sign is reapplied on the way out.
module muldiv_unit
  import multicore_pkg::*;
(
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  input  logic                 i_start,
  input  t_aluop               i_op,
  input  logic [DATA_SIZE-1:0] i_a,
  input  logic [DATA_SIZE-1:0] i_b,
  input  logic                 i_ack,
  output logic                 o_done,
  output logic [DATA_SIZE-1:0] o_result
);

  localparam int W = DATA_SIZE;
  localparam logic [W-1:0] SIGNED_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [5:0]   LAST_ITER  = 6'(MULDIV_ITERS - 1);

  t_md_state        state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic             neg_q, neg_d;    // final result must be negated
  t_aluop           op_q, op_d;

  // Operand conditioning for the start cycle.
  logic         a_signed, b_signed, a_neg, b_neg, div_op, div_zero, div_ovf;
  logic [W-1:0] mag_a, mag_b;

  assign a_signed = i_op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  assign b_signed = i_op inside {ALU_MULH, ALU_DIV, ALU_REM};
  assign a_neg    = a_signed & i_a[W-1];
  assign b_neg    = b_signed & i_b[W-1];
  assign mag_a    = a_neg ? -i_a : i_a;
  assign mag_b    = b_neg ? -i_b : i_b;
  assign div_op   = is_div(i_op);
  assign div_zero = div_op && (i_b == '0);
  assign div_ovf  = (i_op inside {ALU_DIV, ALU_REM}) &&
                    (i_a == SIGNED_MIN) && (i_b == '1);

  // One shift-add step: conditionally add the multiplicand into the
  // high half (keeping the carry) and shift the whole product right.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]}
                             : {1'b0, acc_q[2*W-1:1]};

  // One restoring step: bring the next dividend bit into the partial
  // remainder and subtract the divisor when it fits.
  logic [W:0]     rem_sh, rem_diff;
  logic           rem_ge;
  logic [2*W-1:0] div_next;
  assign rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign rem_ge   = rem_sh >= {1'b0, opnd_q};
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign div_next = {(rem_ge ? rem_diff[W-1:0] : rem_sh[W-1:0]),
                     acc_q[W-2:0], rem_ge};

  // NOTE: every process that assigns in always_comb starts from a full
  // set of defaults so no path can leave a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    op_d    = op_q;
    unique case (state_q)
      MD_IDLE: begin
        if (i_start) begin
          op_d  = i_op;
          cnt_d = '0;
          if (div_zero) begin
            // Quotient all ones, remainder is the raw dividend.
            acc_d   = {i_a, {W{1'b1}}};
            neg_d   = 1'b0;
            state_d = MD_DONE;
          end else if (div_ovf) begin
            acc_d   = {{W{1'b0}}, SIGNED_MIN};
            neg_d   = 1'b0;
            state_d = MD_DONE;
          end else begin
            acc_d   = {{W{1'b0}}, (div_op ? mag_a : mag_b)};
            opnd_d  = div_op ? mag_b : mag_a;
            // Remainder follows the dividend; everything else the XOR.
            neg_d   = (i_op inside {ALU_REM, ALU_REMU}) ? a_neg
                                                        : (a_neg ^ b_neg);
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        acc_d = is_div(op_q) ? div_next : mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) state_d = MD_DONE;
      end
      MD_DONE: begin
        if (i_ack) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  // NOTE: the accumulator and operand registers are reset alongside the
  // FSM; they are a handful of flops, not a memory array, and a known
  // value keeps o_result deterministic after reset.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      op_q    <= ALU_ADD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      op_q    <= op_d;
    end
  end

  // Result selection and sign restoration.
  logic [2*W-1:0] prod;
  logic [W-1:0]   div_word;
  logic [W-1:0]   div_res;

  assign prod     = neg_q ? -acc_q : acc_q;
  assign div_word = (op_q inside {ALU_REM, ALU_REMU}) ? acc_q[2*W-1:W]
                                                      : acc_q[W-1:0];
  assign div_res  = neg_q ? -div_word : div_word;

  assign o_done   = (state_q == MD_DONE);
  assign o_result = is_div(op_q)       ? div_res :
                    (op_q == ALU_MUL)  ? prod[W-1:0] : prod[2*W-1:W];

endmodule

// File: rtl/execute_stage.sv
// execute_stage: pipeline execute stage between decode/register-read
// and mem_access.
// Ports:
//   i_aclk, i_areset_n : clock, async active-low reset
//   bus (slave)        : ID/EX inputs, hazard-unit advance i_en,
//                        registered EX/MEM outputs and stall request o_busy
// Parameter MULDIV_EN: 1 instantiates muldiv_unit, 0 executes M ops as ADD.
// Single-cycle ops are computed combinationally; M ops stall the stage
// (o_busy) while muldiv_unit iterates, during which bubbles are loaded
// into EX/MEM.
module execute_stage
  import multicore_pkg::*;
#(
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic          i_aclk,
  input  logic          i_areset_n,
  execute_stage_if.slave bus
);

  localparam int W = DATA_SIZE;

  logic [4:0]   shamt;
  logic [W-1:0] alu_res;
  logic [W-1:0] exe_res;
  logic         busy;

  assign shamt = bus.i_opb[4:0];

  // M-op encodings fall into the default (ADD); with muldiv enabled the
  // muldiv result replaces it below.
  always_comb begin
    alu_res = bus.i_opa + bus.i_opb;
    case (bus.i_aluop)
      ALU_SUB:   alu_res = bus.i_opa - bus.i_opb;
      ALU_SLL:   alu_res = bus.i_opa << shamt;
      ALU_SLT:   alu_res = {{(W-1){1'b0}},
                            ($signed(bus.i_opa) < $signed(bus.i_opb))};
      ALU_SLTU:  alu_res = {{(W-1){1'b0}}, (bus.i_opa < bus.i_opb)};
      ALU_XOR:   alu_res = bus.i_opa ^ bus.i_opb;
      ALU_SRL:   alu_res = bus.i_opa >> shamt;
      ALU_SRA:   alu_res = W'($signed(bus.i_opa) >>> shamt);
      ALU_OR:    alu_res = bus.i_opa | bus.i_opb;
      ALU_AND:   alu_res = bus.i_opa & bus.i_opb;
      ALU_PASSB: alu_res = bus.i_opb;
      default:   ;
    endcase
  end

  generate
    if (MULDIV_EN) begin : g_muldiv
      logic         md_start;
      logic         md_done;
      logic [W-1:0] md_result;

      // Bubbles never start the unit.
      assign md_start = bus.i_valid & is_muldiv(bus.i_aluop);

      muldiv_unit u_muldiv (
        .i_aclk     (i_aclk),
        .i_areset_n (i_areset_n),
        .i_start    (md_start),
        .i_op       (bus.i_aluop),
        .i_a        (bus.i_opa),
        .i_b        (bus.i_opb),
        .i_ack      (bus.i_en),
        .o_done     (md_done),
        .o_result   (md_result)
      );

      assign busy    = md_start & ~md_done;
      assign exe_res = is_muldiv(bus.i_aluop) ? md_result : alu_res;
    end else begin : g_no_muldiv
      assign busy    = 1'b0;
      assign exe_res = alu_res;
    end
  endgenerate

  assign bus.o_busy = busy;

  // EX/MEM registers. While busy the side-effecting control bits are
  // cleared (bubble); data fields load regardless since they are ignored
  // without those bits. i_en low freezes everything.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      bus.o_exe_out      <= '0;
      bus.o_mem_wdata    <= '0;
      bus.o_pcplus4      <= '0;
      bus.o_rdest        <= '0;
      bus.o_cu_regwrite  <= 1'b0;
      bus.o_cu_memaccess <= 1'b0;
      bus.o_mem_we       <= 1'b0;
      bus.o_cu_memtoreg  <= '0;
      bus.o_ldop         <= LD_B;
      bus.o_sop          <= ST_B;
    end else if (bus.i_en) begin
      bus.o_exe_out      <= exe_res;
      bus.o_mem_wdata    <= bus.i_rs2_data;
      bus.o_pcplus4      <= bus.i_pcplus4;
      bus.o_rdest        <= bus.i_rdest;
      bus.o_cu_regwrite  <= bus.i_cu_regwrite  & bus.i_valid & ~busy;
      bus.o_cu_memaccess <= bus.i_cu_memaccess & bus.i_valid & ~busy;
      bus.o_mem_we       <= bus.i_mem_we       & bus.i_valid & ~busy;
      bus.o_cu_memtoreg  <= bus.i_cu_memtoreg;
      bus.o_ldop         <= bus.i_ldop;
      bus.o_sop          <= bus.i_sop;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;
  import multicore_pkg::*;

  logic i_aclk     = 1'b0;
  logic i_areset_n = 1'b0;

  execute_stage_if bus ();

  execute_stage #(.MULDIV_EN(1'b1)) dut (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .bus        (bus)
  );

  always #5 i_aclk = ~i_aclk;

  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_passed++;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge i_aclk);
    #1;
  endtask

  function automatic logic [31:0] wdata_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] pc_of(input logic [4:0] rd);
    return 32'h0000_1000 + {25'd0, rd, 2'b00};
  endfunction

  task automatic drive(input t_aluop op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    bus.i_en           = 1'b1;
    bus.i_valid        = 1'b1;
    bus.i_aluop        = op;
    bus.i_opa          = a;
    bus.i_opb          = b;
    bus.i_rs2_data     = wdata_of(a);
    bus.i_pcplus4      = pc_of(rd);
    bus.i_rdest        = rd;
    bus.i_cu_regwrite  = 1'b1;
    bus.i_cu_memaccess = 1'b1;
    bus.i_mem_we       = 1'b1;
    bus.i_cu_memtoreg  = 2'b01;
    bus.i_ldop         = LD_HU;
    bus.i_sop          = ST_H;
  endtask

  task automatic run_alu(input string tag, input t_aluop op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
    drive(op, a, b, rd);
    #1;
    check({tag, " busy"}, 64'(bus.o_busy), 64'd0);
    step();
    check({tag, " result"}, 64'(bus.o_exe_out), 64'(exp));
    check({tag, " rdest"}, 64'(bus.o_rdest), 64'(rd));
    check({tag, " wdata"}, 64'(bus.o_mem_wdata), 64'(wdata_of(a)));
    check({tag, " pc"}, 64'(bus.o_pcplus4), 64'(pc_of(rd)));
    check({tag, " ctl"}, 64'({bus.o_cu_memtoreg, bus.o_ldop, bus.o_sop,
                             bus.o_cu_regwrite, bus.o_cu_memaccess,
                             bus.o_mem_we}),
          64'({2'b01, LD_HU, ST_H, 3'b111}));
  endtask

  task automatic run_mop(input string tag, input t_aluop op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp,
                         input int exp_busy);
    int busy_n  = 0;
    int bubbles = 0;
    drive(op, a, b, rd);
    #1;
    while (bus.o_busy && busy_n < 100) begin
      busy_n++;
      step();
      if (!bus.o_cu_regwrite && !bus.o_cu_memaccess && !bus.o_mem_we)
        bubbles++;
    end
    check({tag, " busy cycles"}, 64'(busy_n), 64'(exp_busy));
    check({tag, " bubbles"}, 64'(bubbles), 64'(exp_busy));
    step();
    bus.i_valid = 1'b0;
    check({tag, " result"}, 64'(bus.o_exe_out), 64'(exp));
    check({tag, " regwrite"}, 64'(bus.o_cu_regwrite), 64'd1);
  endtask

  localparam int N_ALU = 14;
  t_aluop      alu_op [N_ALU] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLL,
                                  ALU_SRL, ALU_SRA, ALU_SRA, ALU_SLT,
                                  ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND,
                                  ALU_PASSB, ALU_ADD};
  logic [31:0] alu_a  [N_ALU] = '{32'd5, 32'd3, 32'd1, 32'hFFFF_FFFF,
                                  32'h8000_0000, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'h0000_F0F0,
                                  32'h0000_F0F0, 32'h0000_F0F0,
                                  32'd0, 32'hFFFF_FFFF};
  logic [31:0] alu_b  [N_ALU] = '{32'hFFFF_FFFD, 32'd5, 32'h21, 32'd31,
                                  32'd4, 32'd4, 32'h24, 32'd1, 32'd1,
                                  32'h0000_FF00, 32'h0000_FF00,
                                  32'h0000_FF00, 32'h1234_5000, 32'd1};
  logic [31:0] alu_x  [N_ALU] = '{32'd2, 32'hFFFF_FFFE, 32'd2,
                                  32'h8000_0000, 32'h0800_0000,
                                  32'hF800_0000, 32'h07FF_FFFF, 32'd1,
                                  32'd0, 32'h0000_0FF0, 32'h0000_FFF0,
                                  32'h0000_F000, 32'h1234_5000, 32'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(ALU_ADD, 32'd0, 32'd0, 5'd0);
    bus.i_en    = 1'b0;
    bus.i_valid = 1'b0;
    #12;
    check("reset exe_out", 64'(bus.o_exe_out), 64'd0);
    check("reset regwrite", 64'(bus.o_cu_regwrite), 64'd0);
    check("reset busy", 64'(bus.o_busy), 64'd0);
    @(negedge i_aclk);
    i_areset_n = 1'b1;
    step();

    for (int i = 0; i < N_ALU; i++)
      run_alu($sformatf("alu%0d", i), alu_op[i], alu_a[i], alu_b[i],
              5'(i + 1), alu_x[i]);

    run_mop("mul",     ALU_MUL,   32'd7, 32'hFFFF_FFFD, 5'd1,
            32'hFFFF_FFEB, 33);
    run_mop("mulhu",   ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,
            32'hFFFF_FFFE, 33);
    run_mop("mulh",    ALU_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,
            32'h0000_0000, 33);
    run_mop("mulhsu",  ALU_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4,
            32'hFFFF_FFFF, 33);
    run_mop("div",     ALU_DIV,   32'hFFFF_FFF9, 32'd2, 5'd5,
            32'hFFFF_FFFD, 33);
    run_mop("rem",     ALU_REM,   32'hFFFF_FFF9, 32'd2, 5'd6,
            32'hFFFF_FFFF, 33);
    run_mop("divu",    ALU_DIVU,  32'h64, 32'd7, 5'd7, 32'hE, 33);
    run_mop("divu0",   ALU_DIVU,  32'h1234, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
    run_mop("rem0",    ALU_REM,   32'h1234, 32'd0, 5'd9, 32'h1234, 1);
    run_mop("divovf",  ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd10,
            32'h8000_0000, 1);
    run_mop("removf",  ALU_REM,   32'h8000_0000, 32'hFFFF_FFFF, 5'd11,
            32'h0, 1);

    // Bubble with an M-op encoding: no start, no stall, no write.
    drive(ALU_DIV, 32'd50, 32'd5, 5'd12);
    bus.i_valid = 1'b0;
    #1;
    check("bubble busy", 64'(bus.o_busy), 64'd0);
    step();
    check("bubble busy after", 64'(bus.o_busy), 64'd0);
    check("bubble regwrite", 64'(bus.o_cu_regwrite), 64'd0);

    // DIV reaches DONE, then i_en low for 5 cycles.
    begin
      int n = 0;
      drive(ALU_DIV, 32'hFFFF_FF9C, 32'd7, 5'd13);
      #1;
      while (bus.o_busy && n < 100) begin
        n++;
        step();
      end
      check("hold busy cycles", 64'(n), 64'd33);
      bus.i_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step();
        check($sformatf("hold%0d busy", i), 64'(bus.o_busy), 64'd0);
        check($sformatf("hold%0d regwrite", i), 64'(bus.o_cu_regwrite),
              64'd0);
        check($sformatf("hold%0d rdest", i), 64'(bus.o_rdest), 64'd13);
      end
      bus.i_en = 1'b1;
      step();
      bus.i_valid = 1'b0;
      check("hold result", 64'(bus.o_exe_out), 64'(32'hFFFF_FFF2));
      check("hold regwrite", 64'(bus.o_cu_regwrite), 64'd1);
    end

    // Reset while the multiply is in CALC with cnt = 10.
    drive(ALU_MUL, 32'd3, 32'd5, 5'd14);
    #1;
    for (int i = 0; i < 11; i++) step();
    check("calc busy", 64'(bus.o_busy), 64'd1);
    check("calc bubble", 64'(bus.o_cu_regwrite), 64'd0);
    #2;
    i_areset_n  = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    check("midreset exe_out", 64'(bus.o_exe_out), 64'd0);
    check("midreset rdest", 64'(bus.o_rdest), 64'd0);
    check("midreset pc", 64'(bus.o_pcplus4), 64'd0);
    check("midreset wdata", 64'(bus.o_mem_wdata), 64'd0);
    check("midreset busy", 64'(bus.o_busy), 64'd0);
    @(negedge i_aclk);
    i_areset_n = 1'b1;
    step();
    run_alu("post-reset add", ALU_ADD, 32'h10, 32'h20, 5'd3, 32'h30);
    run_mop("post-reset remu", ALU_REMU, 32'd100, 32'd7, 5'd4, 32'd2, 33);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
